// File: rtl/proc_control_fsm.sv
// Control FSM for the simple processor datapath (R0..R7, A, G, add/sub ALU, bus mux).
// Fetches a 9-bit IIIXXXYYY instruction in T0 and sequences it over T1..T3,
// driving one-hot register selects and the bus/ALU strobes from state + IR.
module proc_control_fsm #(
  parameter int DIN_W = 9
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [DIN_W-1:0] DIN,
  output logic [0:7]       Rin,
  output logic [0:7]       Rout,
  output logic             Ain,
  output logic             Gin,
  output logic             Gout,
  output logic             DINout,
  output logic             IRin,
  output logic             AddSub,
  output logic             Done
);

  localparam logic [1:0] T0 = 2'd0;
  localparam logic [1:0] T1 = 2'd1;
  localparam logic [1:0] T2 = 2'd2;
  localparam logic [1:0] T3 = 2'd3;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  logic [1:0]       state, state_nxt;
  logic [DIN_W-1:0] ir;
  logic [2:0]       op, rx, ry;

  assign op = ir[8:6];
  assign rx = ir[5:3];
  assign ry = ir[2:0];

  // State register and instruction latch; IR only loads on a T0 fetch with Run.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (IRin) ir <= DIN;
    end
  end

  // Next-state and output decode; reset forces every strobe low regardless of state.
  always_comb begin
    state_nxt = T0;
    Rin       = '0;
    Rout      = '0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    Gout      = 1'b0;
    DINout    = 1'b0;
    IRin      = 1'b0;
    AddSub    = 1'b0;
    Done      = 1'b0;
    case (state)
      T0: begin
        IRin      = Run;
        state_nxt = Run ? T1 : T0;
      end
      T1: begin
        case (op)
          OP_MV: begin
            Rout[ry] = 1'b1;
            Rin[rx]  = 1'b1;
            Done     = 1'b1;
          end
          OP_MVI: begin
            DINout  = 1'b1;
            Rin[rx] = 1'b1;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            Rout[rx]  = 1'b1;
            Ain       = 1'b1;
            state_nxt = T2;
          end
          // Reserved opcodes retire as a NOP without touching any register.
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        Rout[ry]  = 1'b1;
        Gin       = 1'b1;
        AddSub    = (op == OP_SUB);
        state_nxt = T3;
      end
      T3: begin
        Gout    = 1'b1;
        Rin[rx] = 1'b1;
        Done    = 1'b1;
      end
      default: state_nxt = T0;
    endcase
    if (!Resetn) begin
      state_nxt = T0;
      Rin       = '0;
      Rout      = '0;
      Ain       = 1'b0;
      Gin       = 1'b0;
      Gout      = 1'b0;
      DINout    = 1'b0;
      IRin      = 1'b0;
      AddSub    = 1'b0;
      Done      = 1'b0;
    end
  end

endmodule
